vram_fill: RTL and testbench
============================

Name: vram_fill

Overview:
- Parametrised video RAM: one write port (CPU side), one read port (display side), built-in hardware fill/clear engine.
- Generalises the current VRAM in data width, depth, write-window base and read latency.
- Adds explicit enables, a read-valid pipeline and an out-of-window write flag.
- Sits between the CPU bus (write side) and the display scan-out logic (read side), on the single system clock.

Parameters:
- DATA_WIDTH, 8: word width in bits.
- READ_ADDR_SIZE, 12: read address width; DEPTH = 2**READ_ADDR_SIZE words.
- WRITE_ADDR_SIZE, 16: CPU write address width.
- WRITE_BASE, 0: first CPU address of the VRAM window. Elaboration error if WRITE_BASE + DEPTH > 2**WRITE_ADDR_SIZE.
- READ_LATENCY, 1: read latency in cycles, legal values 1 or 2. Any other value is an elaboration error.

Ports:
- clk  in  1  system clock; all logic on posedge only.
- rst  in  1  synchronous reset, active low.
- wr_en  in  1  CPU write request.
- wr_addr  in  WRITE_ADDR_SIZE  CPU write address.
- wr_data  in  DATA_WIDTH  CPU write data.
- wr_oob  out  1  one-cycle pulse: previous-cycle write fell outside the window.
- rd_en  in  1  read request.
- rd_addr  in  READ_ADDR_SIZE  read address.
- rd_data  out  DATA_WIDTH  read data.
- rd_valid  out  1  rd_data holds the result of a request.
- fill_start  in  1  start fill of the whole memory.
- fill_value  in  DATA_WIDTH  fill word, sampled with fill_start.
- fill_busy  out  1  fill in progress.
- fill_done  out  1  one-cycle pulse: fill completed.

Behaviour:
- Clock and reset: one clock, synchronous active-low reset on rst.
- Reset (rst=0 at an edge):
  - rd_data=0, rd_valid=0, wr_oob=0, fill_busy=0, fill_done=0.
  - FSM goes to IDLE; fill counter cleared.
  - Memory contents are not reset.
- Write window: in-window when (wr_addr - WRITE_BASE), computed modulo 2**WRITE_ADDR_SIZE, is < DEPTH. Index = that difference.
- CPU write: wr_en=1 and in-window -> mem[index] <= wr_data at that edge.
- Out-of-window write: wr_en=1 and out of window -> no write; wr_oob=1 on the next cycle only.
- Read, READ_LATENCY=1: rd_en sampled at edge T -> rd_data = mem[rd_addr] and rd_valid=1 after T.
- Read, READ_LATENCY=2: same data, presented one edge later (after T+1).
- Read pipeline accepts a request every cycle.
- rd_valid=0 on cycles with no request result; rd_data then holds its last value.
- Collision: read-first. A read and a write (CPU or fill) to the same index at the same edge returns the old data.
- FSM states: IDLE, FILL.
  - IDLE: fill_start=1 -> latch fill_value, counter=0, go to FILL, fill_busy=1 from the next cycle.
  - FILL, each edge: if no in-window CPU write this cycle -> mem[counter] <= latched value, counter+1. Otherwise stall; the CPU write wins and the counter holds.
  - FILL, final word: when the write of index DEPTH-1 commits -> IDLE at the same edge; fill_busy=0 and fill_done=1 for one cycle.
  - Uninterrupted fill: fill_busy high for exactly DEPTH cycles.
- fill_start while in FILL: ignored (no restart, no value change).
- fill_start in the same cycle as a CPU write: both accepted.
- CPU write to an already-filled index during FILL: persists.
- CPU write to a not-yet-filled index during FILL: later overwritten by the fill.
- Out-of-window CPU writes do not stall the fill.
- Reads are allowed during FILL and see the memory state as of each edge.
- Reset mid-fill: fill aborts, no fill_done pulse; the partially filled contents remain.

Test Plan:
- Defaults. Write 0xA5 to 0x0123, then read 0x123 -> rd_valid and rd_data=0xA5 one cycle after rd_en. With READ_LATENCY=2 -> two cycles.
- WRITE_BASE=0x8000, write 0x5A to 0x7FFF and to 0x9000 -> wr_oob pulses once per write; mem unchanged (reads of 0xFFF and 0x000 return prior data).
- Same edge: write 0x11 to index 5 (holding 0x22) and read index 5 -> rd_data=0x22; next read -> 0x11.
- READ_ADDR_SIZE=4, fill_start with fill_value=0x3C ->
  - fill_busy high exactly 16 cycles, fill_done single pulse.
  - All 16 reads return 0x3C.
  - A second fill_start at cycle 5 of the fill is ignored.
- READ_ADDR_SIZE=4, fill 0x00 with CPU writes of 0x77 to index 2 at fill cycle 8 and to index 12 at fill cycle 3 ->
  - busy lasts 18 cycles.
  - Index 2 reads 0x77, index 12 reads 0x00.
- Drop rst to 0 at fill cycle 6 -> fill_busy=0 and rd_valid=0 next cycle, no fill_done; indices 0..5 hold the fill value, the rest hold old data.

Source files
------------

// File: rtl/vram_fill_if.sv
// vram_fill_if: bus bundle between the CPU/display side and vram_fill.
//   master modport: drives write, read and fill requests; receives status and read data.
//   slave modport:  the memory side (vram_fill).
// Signals:
//   wr_en/wr_addr/wr_data  CPU write request
//   wr_oob                 one-cycle pulse, previous write fell outside the window
//   rd_en/rd_addr          read request
//   rd_data/rd_valid       read result
//   fill_start/fill_value  fill request and fill word
//   fill_busy/fill_done    fill status
interface vram_fill_if #(
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned READ_ADDR_SIZE  = 12,
  parameter int unsigned WRITE_ADDR_SIZE = 16
);
  logic                       wr_en;
  logic [WRITE_ADDR_SIZE-1:0] wr_addr;
  logic [DATA_WIDTH-1:0]      wr_data;
  logic                       wr_oob;
  logic                       rd_en;
  logic [READ_ADDR_SIZE-1:0]  rd_addr;
  logic [DATA_WIDTH-1:0]      rd_data;
  logic                       rd_valid;
  logic                       fill_start;
  logic [DATA_WIDTH-1:0]      fill_value;
  logic                       fill_busy;
  logic                       fill_done;

  modport master (
    output wr_en, wr_addr, wr_data, rd_en, rd_addr, fill_start, fill_value,
    input  wr_oob, rd_data, rd_valid, fill_busy, fill_done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr, fill_start, fill_value,
    output wr_oob, rd_data, rd_valid, fill_busy, fill_done
  );
endinterface

// File: rtl/vram_fill.sv
// vram_fill: video RAM with a CPU write port, a display read port and a whole-memory
// fill engine, all on one clock.
// Ports:
//   clk     system clock (posedge only)
//   rst     synchronous reset, active low
//   bus_io  vram_fill_if.slave: write/read/fill requests and status
// The CPU sees the memory as a window of 2**READ_ADDR_SIZE words starting at WRITE_BASE.
// Reads are read-first and take READ_LATENCY (1 or 2) cycles. During a fill, an in-window
// CPU write takes the single write port and the fill stalls for that cycle.
module vram_fill #(
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned READ_ADDR_SIZE  = 12,
  parameter int unsigned WRITE_ADDR_SIZE = 16,
  parameter int unsigned WRITE_BASE      = 0,
  parameter int unsigned READ_LATENCY    = 1
) (
  input logic        clk,
  input logic        rst,
  vram_fill_if.slave bus_io
);

  localparam int unsigned Depth = 2 ** READ_ADDR_SIZE;
  localparam logic [WRITE_ADDR_SIZE-1:0] WriteBase = WRITE_ADDR_SIZE'(WRITE_BASE);
  localparam logic [READ_ADDR_SIZE-1:0]  LastIdx   = '1;

  // Parameter legality
  if ((64'(WRITE_BASE) + (64'd1 << READ_ADDR_SIZE)) > (64'd1 << WRITE_ADDR_SIZE)) begin : g_bad_win
    $error("vram_fill: WRITE_BASE + DEPTH exceeds the write address space");
  end
  if ((READ_LATENCY != 1) && (READ_LATENCY != 2)) begin : g_bad_lat
    $error("vram_fill: READ_LATENCY must be 1 or 2");
  end

  typedef enum logic [0:0] {StIdle, StFill} state_e;

  state_e                    state_q, state_d;
  logic [READ_ADDR_SIZE-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]     fill_val_q, fill_val_d;
  logic                      done_q, done_d;
  logic                      oob_q, oob_d;

  logic [DATA_WIDTH-1:0]     mem_q [Depth];

  // Write window decode; the subtraction wraps modulo 2**WRITE_ADDR_SIZE.
  logic [WRITE_ADDR_SIZE-1:0] wr_off;
  logic                       in_win;
  logic [READ_ADDR_SIZE-1:0]  wr_idx;
  logic                       cpu_we;

  assign wr_off = bus_io.wr_addr - WriteBase;
  assign in_win = (wr_off >> READ_ADDR_SIZE) == '0;
  assign wr_idx = wr_off[READ_ADDR_SIZE-1:0];
  assign cpu_we = bus_io.wr_en && in_win;

  // Single memory write port shared by CPU and fill engine
  logic                      mem_we;
  logic [READ_ADDR_SIZE-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0]     mem_wdata;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    fill_val_d = fill_val_q;
    done_d     = 1'b0;
    oob_d      = bus_io.wr_en && !in_win;
    mem_we     = cpu_we;
    mem_waddr  = wr_idx;
    mem_wdata  = bus_io.wr_data;

    unique case (state_q)
      StIdle: begin
        if (bus_io.fill_start) begin
          fill_val_d = bus_io.fill_value;
          cnt_d      = '0;
          state_d    = StFill;
        end
      end
      StFill: begin
        // CPU write owns the port this cycle; fill holds its position
        if (!cpu_we) begin
          mem_we    = 1'b1;
          mem_waddr = cnt_q;
          mem_wdata = fill_val_q;
          if (cnt_q == LastIdx) begin
            state_d = StIdle;
            done_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      fill_val_q <= '0;
      done_q     <= 1'b0;
      oob_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fill_val_q <= fill_val_d;
      done_q     <= done_d;
      oob_q      <= oob_d;
    end
  end

  // Contents survive reset, but nothing is written on a reset edge so an aborted fill
  // leaves exactly the words committed before it.
  always_ff @(posedge clk) begin
    if (rst && mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // First read stage; non-blocking update of mem_q gives read-first on collisions.
  logic                  rd1_valid_q;
  logic [DATA_WIDTH-1:0] rd1_data_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd1_valid_q <= 1'b0;
      rd1_data_q  <= '0;
    end else begin
      rd1_valid_q <= bus_io.rd_en;
      if (bus_io.rd_en) begin
        rd1_data_q <= mem_q[bus_io.rd_addr];
      end
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic                  rd2_valid_q;
    logic [DATA_WIDTH-1:0] rd2_data_q;

    always_ff @(posedge clk) begin
      if (!rst) begin
        rd2_valid_q <= 1'b0;
        rd2_data_q  <= '0;
      end else begin
        rd2_valid_q <= rd1_valid_q;
        if (rd1_valid_q) begin
          rd2_data_q <= rd1_data_q;
        end
      end
    end

    assign bus_io.rd_valid = rd2_valid_q;
    assign bus_io.rd_data  = rd2_data_q;
  end else begin : g_lat1
    assign bus_io.rd_valid = rd1_valid_q;
    assign bus_io.rd_data  = rd1_data_q;
  end

  assign bus_io.wr_oob    = oob_q;
  assign bus_io.fill_busy = (state_q == StFill);
  assign bus_io.fill_done = done_q;

endmodule

// File: tb/tb_vram_fill.sv
// tb_vram_fill: directed bench for vram_fill with three parameterisations:
//   ua  defaults (12-bit read address, base 0, latency 1)
//   ub  base 0x8000, latency 2
//   uc  16-word memory, latency 1 (fill engine)
module tb_vram_fill;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  vram_fill_if #(.DATA_WIDTH(8), .READ_ADDR_SIZE(12), .WRITE_ADDR_SIZE(16)) ia ();
  vram_fill_if #(.DATA_WIDTH(8), .READ_ADDR_SIZE(12), .WRITE_ADDR_SIZE(16)) ib ();
  vram_fill_if #(.DATA_WIDTH(8), .READ_ADDR_SIZE(4),  .WRITE_ADDR_SIZE(16)) ic ();

  vram_fill #(.DATA_WIDTH(8), .READ_ADDR_SIZE(12), .WRITE_ADDR_SIZE(16), .WRITE_BASE(0),
              .READ_LATENCY(1)) ua (.clk(clk), .rst(rst), .bus_io(ia));
  vram_fill #(.DATA_WIDTH(8), .READ_ADDR_SIZE(12), .WRITE_ADDR_SIZE(16), .WRITE_BASE(32'h8000),
              .READ_LATENCY(2)) ub (.clk(clk), .rst(rst), .bus_io(ib));
  vram_fill #(.DATA_WIDTH(8), .READ_ADDR_SIZE(4), .WRITE_ADDR_SIZE(16), .WRITE_BASE(0),
              .READ_LATENCY(1)) uc (.clk(clk), .rst(rst), .bus_io(ic));

  int n_pass  = 0;
  int n_total = 0;
  int busy_cnt, done_cnt, done_at;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Single latency-1 read on uc; checks {rd_valid, rd_data}
  task automatic c_read(input int idx, input logic [7:0] exp, input string tag);
    ic.rd_en   = 1'b1;
    ic.rd_addr = 4'(idx);
    tick();
    ic.rd_en = 1'b0;
    chk(tag, {23'd0, ic.rd_valid, ic.rd_data}, {23'd0, 1'b1, exp});
  endtask

  initial begin
    ia.wr_en = 0; ia.wr_addr = '0; ia.wr_data = '0; ia.rd_en = 0; ia.rd_addr = '0;
    ia.fill_start = 0; ia.fill_value = '0;
    ib.wr_en = 0; ib.wr_addr = '0; ib.wr_data = '0; ib.rd_en = 0; ib.rd_addr = '0;
    ib.fill_start = 0; ib.fill_value = '0;
    ic.wr_en = 0; ic.wr_addr = '0; ic.wr_data = '0; ic.rd_en = 0; ic.rd_addr = '0;
    ic.fill_start = 0; ic.fill_value = '0;

    // Reset state
    tick(); tick();
    chk("reset_a", {ia.rd_valid, ia.rd_data, ia.wr_oob, ia.fill_busy, ia.fill_done}, 0);
    chk("reset_b", {ib.rd_valid, ib.rd_data, ib.wr_oob, ib.fill_busy, ib.fill_done}, 0);
    chk("reset_c", {ic.rd_valid, ic.rd_data, ic.wr_oob, ic.fill_busy, ic.fill_done}, 0);
    rst = 1'b1;
    tick();

    // Latency-1 write then read
    ia.wr_en = 1; ia.wr_addr = 16'h0123; ia.wr_data = 8'hA5;
    tick();
    ia.wr_en = 0; ia.rd_en = 1; ia.rd_addr = 12'h123;
    tick();
    ia.rd_en = 0;
    chk("lat1_read", {ia.rd_valid, ia.rd_data}, {1'b1, 8'hA5});
    tick();
    chk("lat1_idle_hold", {ia.rd_valid, ia.rd_data}, {1'b0, 8'hA5});

    // Read-first collision on index 5
    ia.wr_en = 1; ia.wr_addr = 16'h0005; ia.wr_data = 8'h22;
    tick();
    ia.wr_data = 8'h11; ia.rd_en = 1; ia.rd_addr = 12'h005;
    tick();
    ia.wr_en = 0;
    chk("collide_old", {ia.rd_valid, ia.rd_data}, {1'b1, 8'h22});
    tick();
    ia.rd_en = 0;
    chk("collide_new", {ia.rd_valid, ia.rd_data}, {1'b1, 8'h11});

    // Out-of-window write with base 0
    ia.wr_en = 1; ia.wr_addr = 16'h1000; ia.wr_data = 8'hEE;
    tick();
    ia.wr_en = 0;
    chk("oob_a_pulse", {31'd0, ia.wr_oob}, 1);
    tick();
    chk("oob_a_clear", {31'd0, ia.wr_oob}, 0);

    // Latency-2 read on ub (base 0x8000)
    ib.wr_en = 1; ib.wr_addr = 16'h8123; ib.wr_data = 8'hA5;
    tick();
    ib.wr_en = 0; ib.rd_en = 1; ib.rd_addr = 12'h123;
    tick();
    ib.rd_en = 0;
    chk("lat2_not_yet", {31'd0, ib.rd_valid}, 0);
    tick();
    chk("lat2_read", {ib.rd_valid, ib.rd_data}, {1'b1, 8'hA5});
    tick();
    chk("lat2_idle", {31'd0, ib.rd_valid}, 0);

    // Window edges on ub: preload both ends, then two out-of-window writes
    ib.wr_en = 1; ib.wr_addr = 16'h8FFF; ib.wr_data = 8'h44;
    tick();
    ib.wr_addr = 16'h8000; ib.wr_data = 8'h55;
    tick();
    chk("in_win_no_oob", {31'd0, ib.wr_oob}, 0);
    ib.wr_addr = 16'h7FFF; ib.wr_data = 8'h5A;
    tick();
    chk("oob_below", {31'd0, ib.wr_oob}, 1);
    ib.wr_addr = 16'h9000;
    tick();
    ib.wr_en = 0;
    chk("oob_above", {31'd0, ib.wr_oob}, 1);
    tick();
    chk("oob_b_clear", {31'd0, ib.wr_oob}, 0);
    ib.rd_en = 1; ib.rd_addr = 12'hFFF;
    tick();
    ib.rd_addr = 12'h000;
    tick();
    ib.rd_en = 0;
    chk("oob_keep_fff", {ib.rd_valid, ib.rd_data}, {1'b1, 8'h44});
    tick();
    chk("oob_keep_000", {ib.rd_valid, ib.rd_data}, {1'b1, 8'h55});

    // Fill 0x3C on uc, second fill_start at fill cycle 5 must be ignored
    ic.fill_start = 1; ic.fill_value = 8'h3C;
    tick();
    busy_cnt = 0; done_cnt = 0; done_at = -1;
    for (int i = 0; i < 30; i++) begin
      if (ic.fill_busy) busy_cnt++;
      if (ic.fill_done) begin done_cnt++; done_at = i; end
      ic.fill_start = (i == 5);
      ic.fill_value = (i == 5) ? 8'h99 : 8'h3C;
      tick();
    end
    ic.fill_start = 0;
    chk("fill1_busy_len", busy_cnt, 16);
    chk("fill1_done_cnt", done_cnt, 1);
    chk("fill1_done_at", done_at, 16);
    for (int k = 0; k < 16; k++) c_read(k, 8'h3C, $sformatf("fill1_word%0d", k));

    // Fill 0x00 with CPU writes at fill cycles 3 (idx 12) and 8 (idx 2), plus an
    // out-of-window write at cycle 10 that must not stall
    ic.fill_start = 1; ic.fill_value = 8'h00;
    tick();
    ic.fill_start = 0;
    busy_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      if (ic.fill_busy) busy_cnt++;
      if (ic.fill_done) done_cnt++;
      ic.wr_en   = (i == 3) || (i == 8) || (i == 10);
      ic.wr_addr = (i == 3) ? 16'h000C : (i == 8) ? 16'h0002 : 16'h0040;
      ic.wr_data = 8'h77;
      tick();
    end
    ic.wr_en = 0;
    chk("fill2_busy_len", busy_cnt, 18);
    chk("fill2_done_cnt", done_cnt, 1);
    c_read(2, 8'h77, "fill2_idx2_persist");
    c_read(12, 8'h00, "fill2_idx12_overwr");
    c_read(0, 8'h00, "fill2_idx0");

    // Fill 0xC3, reset during fill cycle 6 (after 6 words committed)
    ic.fill_start = 1; ic.fill_value = 8'hC3;
    tick();
    ic.fill_start = 0;
    for (int i = 0; i < 6; i++) tick();
    chk("abort_busy_pre", {31'd0, ic.fill_busy}, 1);
    rst = 1'b0;
    ic.rd_en = 1; ic.rd_addr = 4'd0;
    tick();
    rst = 1'b1;
    ic.rd_en = 0;
    chk("abort_state", {ic.fill_busy, ic.rd_valid, ic.fill_done}, 0);
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (ic.fill_done) done_cnt++;
      tick();
    end
    chk("abort_no_done", done_cnt, 0);
    c_read(0, 8'hC3, "abort_idx0");
    c_read(2, 8'hC3, "abort_idx2");
    c_read(5, 8'hC3, "abort_idx5");
    c_read(6, 8'h00, "abort_idx6");
    c_read(15, 8'h00, "abort_idx15");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
